// File: rtl/tc_pl_cap_accum_buff.sv
// Accumulation buffer controller: owns the frame memory, serves the add stage, streams the finished frame.
// Optional sequencing-error checks are built when CAP_ACC_ERR_CHECK_EN is defined.
module tc_pl_cap_accum_buff #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   frame_len,
    input  logic [CNT_W-1:0]  acc_num,
    output logic              busy,
    output logic              done,
    output logic              add_add,
    input  logic              buff_dout_req,
    output logic [DATA_W-1:0] buff_dout,
    input  logic [DATA_W-1:0] buff_din,
    input  logic              buff_din_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_READOUT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] len_m1_q;
    logic [CNT_W-1:0]  acc_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0]  fcnt_q;
    logic              add_add_q;
    logic [ADDR_W-1:0] ro_addr_q;
    logic              ro_issued_q;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_rd_q;
    logic              rd_acc_vld_q;
    logic              rd_ro_vld_q;
    logic              rd_ro_last_q;
    logic [DATA_W-1:0] buff_dout_q;

    logic [DATA_W-1:0] skid_data_q [2];
    logic              skid_last_q [2];
    logic [1:0]        skid_cnt_q;

    logic [ADDR_W-1:0] len_m1_clamp;
    logic [CNT_W-1:0]  acc_clamp;
    logic              in_accum;
    logic              wr_en;
    logic              acc_rd;
    logic              wr_wrap;
    logic              rd_wrap;
    logic              last_frame_wr;
    logic              pop;
    logic              push;
    logic [2:0]        occ;
    logic              ro_issue;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              last_hs;

    // Clamp the programmed length to 1..DEPTH and store it as a last-index.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        len_m1_clamp = '0;
        if (frame_len == '0)
            len_m1_clamp = '0;
        else if (frame_len[ADDR_W])
            len_m1_clamp = '1;
        else
            len_m1_clamp = frame_len[ADDR_W-1:0] - ADDR_W'(1);
    end

    assign acc_clamp     = (acc_num == '0) ? CNT_W'(1) : acc_num;
    assign in_accum      = (state_q == S_ACCUM);
    assign wr_en         = in_accum & buff_din_valid;
    assign acc_rd        = in_accum & add_add_q & buff_dout_req;
    assign wr_wrap       = (wr_ptr_q == len_m1_q);
    assign rd_wrap       = (rd_ptr_q == len_m1_q);
    assign last_frame_wr = wr_en & wr_wrap & ((fcnt_q + CNT_W'(1)) == acc_q);

    // Readout credit: words in flight plus words held must never exceed the two skid slots.
    assign out_valid = (skid_cnt_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign push      = rd_ro_vld_q;
    assign occ       = {1'b0, skid_cnt_q} + {2'b00, rd_ro_vld_q};
    assign ro_issue  = (state_q == S_READOUT) & ~ro_issued_q & (occ <= ({2'b00, pop} + 3'd1));
    assign rd_en     = acc_rd | ro_issue;
    assign rd_addr   = (state_q == S_READOUT) ? ro_addr_q : rd_ptr_q;
    assign last_hs   = pop & skid_last_q[0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start) state_d = S_ACCUM;
            S_ACCUM:   if (last_frame_wr) state_d = S_READOUT;
            S_READOUT: if (last_hs) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_m1_q    <= '0;
            acc_q       <= CNT_W'(1);
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fcnt_q      <= '0;
            add_add_q   <= 1'b0;
            ro_addr_q   <= '0;
            ro_issued_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_m1_q  <= len_m1_clamp;
                        acc_q     <= acc_clamp;
                        wr_ptr_q  <= '0;
                        rd_ptr_q  <= '0;
                        fcnt_q    <= '0;
                        add_add_q <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (wr_en) begin
                        wr_ptr_q <= wr_wrap ? '0 : wr_ptr_q + ADDR_W'(1);
                        if (wr_wrap) fcnt_q <= fcnt_q + CNT_W'(1);
                    end
                    if (acc_rd)
                        rd_ptr_q <= rd_wrap ? '0 : rd_ptr_q + ADDR_W'(1);
                    if (last_frame_wr) begin
                        add_add_q   <= 1'b0;
                        ro_addr_q   <= '0;
                        ro_issued_q <= 1'b0;
                    end else if (wr_en && wr_wrap && fcnt_q == '0) begin
                        add_add_q <= 1'b1;
                    end
                end
                S_READOUT: begin
                    if (ro_issue) begin
                        ro_addr_q <= ro_addr_q + ADDR_W'(1);
                        if (ro_addr_q == len_m1_q) ro_issued_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the frame memory and its read register are not reset; valid flags gate everything they feed.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= buff_din;
        if (rd_en) mem_rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_acc_vld_q <= 1'b0;
            rd_ro_vld_q  <= 1'b0;
            rd_ro_last_q <= 1'b0;
            buff_dout_q  <= '0;
        end else begin
            rd_acc_vld_q <= acc_rd;
            rd_ro_vld_q  <= ro_issue;
            rd_ro_last_q <= ro_issue & (ro_addr_q == len_m1_q);
            if (rd_acc_vld_q) buff_dout_q <= mem_rd_q;
        end
    end

    // Two-slot skid buffer; slot 0 is the presented word.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_cnt_q     <= 2'd0;
            skid_data_q[0] <= '0;
            skid_data_q[1] <= '0;
            skid_last_q[0] <= 1'b0;
            skid_last_q[1] <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (skid_cnt_q == 2'd0) begin
                        skid_data_q[0] <= mem_rd_q;
                        skid_last_q[0] <= rd_ro_last_q;
                    end else begin
                        skid_data_q[1] <= mem_rd_q;
                        skid_last_q[1] <= rd_ro_last_q;
                    end
                    skid_cnt_q <= skid_cnt_q + 2'd1;
                end
                2'b01: begin
                    skid_data_q[0] <= skid_data_q[1];
                    skid_last_q[0] <= skid_last_q[1];
                    skid_cnt_q     <= skid_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (skid_cnt_q == 2'd1) begin
                        skid_data_q[0] <= mem_rd_q;
                        skid_last_q[0] <= rd_ro_last_q;
                    end else begin
                        skid_data_q[0] <= skid_data_q[1];
                        skid_last_q[0] <= skid_last_q[1];
                        skid_data_q[1] <= mem_rd_q;
                        skid_last_q[1] <= rd_ro_last_q;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CAP_ACC_ERR_CHECK_EN
    logic [CNT_W-1:0] rfcnt_q;
    logic             err_q;
    logic             rd_ahead;
    logic             err_set;

    // rfcnt_q is the frame index the add stage is reading; reads begin with frame 1.
    assign rd_ahead = (rfcnt_q > fcnt_q) | ((rfcnt_q == fcnt_q) & (rd_ptr_q > wr_ptr_q));
    assign err_set  = (wr_en & add_add_q & ~rd_ahead)
                    | (acc_rd & (rfcnt_q >= acc_q))
                    | (acc_rd & (fcnt_q == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            rfcnt_q <= CNT_W'(1);
            err_q   <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            rfcnt_q <= CNT_W'(1);
            err_q   <= 1'b0;
        end else begin
            if (acc_rd && rd_wrap) rfcnt_q <= rfcnt_q + CNT_W'(1);
            if (err_set) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign add_add   = add_add_q;
    assign buff_dout = buff_dout_q;
    assign out_data  = skid_data_q[0];
    assign out_last  = skid_last_q[0] & out_valid;

endmodule

// File: tb/tb_tc_pl_cap_accum_buff.sv
// Scoreboard bench for tc_pl_cap_accum_buff: a modelled add stage drives the buffer, a monitor checks
// buff_dout and the readout stream against lane-wise running sums kept by the bench.
module tb_tc_pl_cap_accum_buff;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   frame_len;
    logic [CNT_W-1:0]  acc_num;
    logic              busy;
    logic              done;
    logic              add_add;
    logic              buff_dout_req;
    logic [DATA_W-1:0] buff_dout;
    logic [DATA_W-1:0] buff_din;
    logic              buff_din_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              err;

    tc_pl_cap_accum_buff #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .acc_num(acc_num),
        .busy(busy), .done(done), .add_add(add_add),
        .buff_dout_req(buff_dout_req), .buff_dout(buff_dout),
        .buff_din(buff_din), .buff_din_valid(buff_din_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] dout_q[$];
    logic [DATA_W:0]   ro_q[$];
    logic [DATA_W-1:0] psum [DEPTH];

    int cyc = 0;
    int done_cnt, hs_cnt, first_hs, last_hs;
    bit [1:0] hist = 2'b00;

`ifdef CAP_ACC_ERR_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] ladd(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        for (int l = 0; l < 4; l++) r[l*32 +: 32] = a[l*32 +: 32] + b[l*32 +: 32];
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] gen(input int pat, input int i);
        case (pat)
            1:       return DATA_W'(i + 1);
            2:       return {4{32'd5}};
            default: return {$urandom, $urandom, $urandom, $urandom};
        endcase
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: buff_dout is due two cycles after each sampled request; readout checked on handshake.
    always @(negedge clk) begin
        if (rst) begin
            hist = 2'b00;
        end else begin
            if (hist[1]) begin
                if (dout_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL buff_dout_unexpected: got %h expected nothing", buff_dout);
                end else begin
                    check("buff_dout", buff_dout, dout_q.pop_front());
                end
            end
            hist = {hist[0], buff_dout_req};
            if (out_valid && out_ready) begin
                if (ro_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL readout_extra: got %h expected nothing", out_data);
                end else begin
                    check("readout_word", {out_last, out_data}, ro_q.pop_front());
                end
                if (hs_cnt == 0) first_hs = cyc;
                last_hs = cyc;
                hs_cnt++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic do_frame(input int f, input int n, input int pat);
        logic [DATA_W-1:0] xv[$];
        for (int i = 0; i < n; i++) xv.push_back(gen(pat, i));
        if (f == 0) begin
            for (int i = 0; i < n; i++) begin
                buff_din = xv[i];
                buff_din_valid = 1'b1;
                psum[i] = xv[i];
                tick();
            end
        end else begin
            for (int c = 0; c < n + 2; c++) begin
                buff_dout_req = (c < n);
                if (c < n) dout_q.push_back(psum[c]);
                if (c >= 2) begin
                    buff_din = ladd(buff_dout, xv[c-2]);
                    buff_din_valid = 1'b1;
                    psum[c-2] = ladd(psum[c-2], xv[c-2]);
                end else begin
                    buff_din_valid = 1'b0;
                end
                tick();
            end
        end
        buff_dout_req = 1'b0;
        buff_din_valid = 1'b0;
    endtask

    task automatic begin_run(input int fl, input int an);
        frame_len = fl[ADDR_W:0];
        acc_num = an[CNT_W-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic run(input int fl, input int an, input int rdy, input int pat);
        int L, A, budget;
        L = (fl == 0) ? 1 : ((fl > DEPTH) ? DEPTH : fl);
        A = (an == 0) ? 1 : an;
        done_cnt = 0; hs_cnt = 0; first_hs = 0; last_hs = 0;
        begin_run(fl, an);
        for (int f = 0; f < A; f++) begin
            check("add_add_frame", add_add, (f > 0));
            do_frame(f, L, pat);
            if (f < A - 1) repeat (8) tick();
        end
        check("add_add_after_last", add_add, 1'b0);
        for (int i = 0; i < L; i++) ro_q.push_back({(i == L - 1), psum[i]});
        budget = L * 20 + 100;
        for (int n = 0; n < budget && done_cnt == 0; n++) begin
            out_ready = ($urandom_range(0, 99) < rdy);
            tick();
        end
        check("done_seen", (done_cnt > 0), 1'b1);
        out_ready = 1'b0;
        repeat (3) tick();
        check("done_once", done_cnt, 1);
        check("busy_idle", busy, 1'b0);
        check("readout_count", hs_cnt, L);
        check("readout_left", ro_q.size(), 0);
        check("err_clean", err, 1'b0);
        if (rdy >= 100) check("throughput", last_hs - first_hs, L - 1);
        ro_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; frame_len = '0; acc_num = '0;
        buff_dout_req = 1'b0; buff_din = '0; buff_din_valid = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_add_add", add_add, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_buff_dout", buff_dout, '0);
        check("rst_out_data", out_data, '0);
        rst = 1'b0;
        tick();

        run(4, 1, 100, 1);
        run(8, 3, 100, 2);
        check("lane_sum_15", psum[7], {4{32'd15}});
        run(5, 4, 70, 0);
        run(16, 2, 50, 0);
        run(0, 0, 50, 0);
        run(1100, 2, 80, 0);

        // Reset in the middle of frame 1 of a four-frame run.
        begin_run(8, 4);
        do_frame(0, 8, 0);
        repeat (8) tick();
        do_frame(1, 3, 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_add_add", add_add, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_buff_dout", buff_dout, '0);
        dout_q.delete();
        run(8, 4, 60, 0);

        // Write in frame 1 with no preceding read.
        begin_run(4, 2);
        do_frame(0, 4, 0);
        repeat (8) tick();
        buff_din = '1;
        buff_din_valid = 1'b1;
        tick();
        buff_din_valid = 1'b0;
        tick();
        check("err_set", err, ERR_EXP);
        repeat (5) tick();
        check("err_sticky", err, ERR_EXP);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("err_cleared", err, 1'b0);
        run(4, 2, 100, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tc_pl_cap_accum_buff.md
# tc_pl_cap_accum_buff

Accumulation buffer controller that sits directly downstream of the capture add stage. It owns the on-chip frame memory and serves the add stage's read requests (`buff_dout_req` → `buff_dout`). It stores the summed words the add stage writes back (`buff_din`/`buff_din_valid`) and drives its `add_add` select. After a programmed number of frames have been accumulated, it streams the finished frame out over a valid/ready interface toward the PS/DMA side.

## Interface
Parameters:
- `DATA_W`, 128, buffer word width (4 lanes × 32 bit)
- `ADDR_W`, 10, address width; memory depth = 2^ADDR_W words
- `CNT_W`, 16, width of frame-count register

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high; clock `clk`
- `start`  in  1  one-cycle pulse, begin a capture run (sampled in IDLE only)
- `frame_len`  in  ADDR_W+1  words per frame, sampled on `start`
- `acc_num`  in  CNT_W  frames to accumulate, sampled on `start`
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle pulse after last readout handshake
- `add_add`  out  1  0 = add stage adds zero (first frame), 1 = add buffer contents
- `buff_dout_req`  in  1  read request from add stage, one word per cycle
- `buff_dout`  out  DATA_W  read data
- `buff_din`  in  DATA_W  accumulated word to write
- `buff_din_valid`  in  1  write strobe
- `out_data`  out  DATA_W  readout word
- `out_valid`  out  1  readout valid
- `out_ready`  in  1  readout ready
- `out_last`  out  1  marks final readout word
- `err`  out  1  sticky sequencing error (see Configuration)

## Operation
- The internal memory is a simple dual-port array of 2^ADDR_W × DATA_W. The read port is registered, and the output register adds one more stage.
- On `start`, `frame_len` is clamped to the range 1..2^ADDR_W, and a `frame_len` of 0 is treated as 1. An `acc_num` of 0 is treated as 1.
- States:
  - IDLE: waits for `start`; on `start` → ACCUM.
  - ACCUM: performs the accumulation.
  - READOUT: streams the finished frame out.
  - DONE: transitional state → IDLE.
- ACCUM:
  - Pointers `wr_ptr` and `rd_ptr` start at 0, and the frame counter `fcnt` starts at 0.
  - Each `buff_din_valid` writes `buff_din` to `mem[wr_ptr]`, then increments `wr_ptr`.
  - When `wr_ptr` reaches `frame_len-1`, it wraps to 0 and `fcnt` increments.
  - Each `buff_dout_req` while `add_add`=1 reads `mem[rd_ptr]`, then increments `rd_ptr`, wrapping at `frame_len-1`.
  - While `add_add`=0, `buff_dout_req` is ignored.
- `add_add` is 0 throughout frame 0. It rises to 1 the cycle after the final write of frame 0, and stays 1 until leaving ACCUM.
- When the write that wraps `fcnt` to `acc_num` occurs, the block goes to READOUT and `add_add` drops to 0 in the next cycle.
- READOUT:
  - Addresses 0..`frame_len-1` are read in order.
  - A 2-entry skid buffer decouples the 2-cycle read latency from `out_ready`; no word is dropped or duplicated under arbitrary backpressure.
  - `out_last` accompanies word `frame_len-1`.
  - After the last handshake, the block enters DONE, pulses `done` for one cycle, and returns to IDLE.
- Outside ACCUM, `buff_din_valid` and `buff_dout_req` are ignored.
- `start` outside IDLE is ignored.
- Memory contents are never cleared. Frame 0 overwrites them because `add_add`=0.
- Upstream guarantees a gap of at least 8 idle cycles between frames, so the frame-0 writes complete before the frame-1 reads.

## Timing
- Reset values:
  - `busy`, `done`, `add_add`, `out_valid`, `out_last` and `err` reset to 0.
  - `buff_dout` and `out_data` reset to 0.
  - The state resets to IDLE, and the pointers and `fcnt` reset to 0.
- `busy` rises the cycle after `start`.
- `buff_dout` is valid exactly 2 cycles after the cycle `buff_dout_req` is sampled high, and holds its value otherwise.
- Writes take effect in the cycle after the strobe. A read issued in the same cycle as a write to the same address returns the old data.
- Readout: the first `out_valid` appears no later than 3 cycles after entering READOUT. With `out_ready` held at 1, the throughput is one word per cycle.
- Reset mid-run: the block returns to IDLE on the next edge and all outputs take their reset values. Any in-flight skid data is discarded.

## Configuration
- `CAP_ACC_ERR_CHECK_EN` defined:
  - `err` is set when any of these occurs:
    - In ACCUM with `add_add`=1, `buff_din_valid` arrives while the write count of the current frame is ≥ the read count.
    - `buff_dout_req` arrives after `rd_ptr` has already completed the frame count for `acc_num`.
    - The frame-0 writes are incomplete when the first `buff_dout_req` with `add_add`=1 arrives.
  - `err` is sticky until `rst` or the next accepted `start`.
- Undefined: `err` is tied to 0 and no check logic is built.

## Test plan
- `frame_len`=4, `acc_num`=1, writes 1,2,3,4: `add_add` stays 0, readout is 1,2,3,4 with `out_last` on 4, and `done` pulses once.
- `frame_len`=8, `acc_num`=3, with the accumulator model adding a constant 5 to each lane: readout lanes are all 15, and `add_add` is 0,1,1 per frame.
- Read latency: `buff_dout_req` at cycle N returns `mem[rd_ptr]` at cycle N+2, checked across the `frame_len`-1→0 wrap.
- Readout with `out_ready` random at 50%, `frame_len`=16: 16 words in order, no drops or duplicates, `out_last` only on word 15.
- `rst` asserted mid-frame 1 of a 4-frame run: next cycle `busy`=0 and `add_add`=0; a fresh `start` then completes correctly.
- With `CAP_ACC_ERR_CHECK_EN`, issue `buff_din_valid` in frame 1 with no preceding read: `err`=1 and it persists. Without the macro, `err`=0.
